// File: rtl/cache_fill_ctrl_if.sv
// Bundle of request, LRU, victim, memory and data-array fill signals
// around the cache miss/refill controller.
//   master : controller side (cache_fill_ctrl)
//   slave  : environment side (tag compare, lru, data array, memory bus)
// Widths follow the controller parameters: OFF_W = log2(WORDS), and CNT_W
// keeps the word counter at least one bit wide when WORDS = 1.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4,
  parameter int WORDS   = 4,
  parameter int OFF_W   = $clog2(WORDS),
  parameter int CNT_W   = (OFF_W > 0) ? OFF_W : 1,
  parameter int TAG_W   = ADDR_W - INDEX_W - OFF_W - 2
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_hit;
  logic [1:0]        req_hit_way;
  logic [1:0]        lru_way;
  logic              victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic [31:0]       victim_rdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  logic              busy;
  logic              done;
  logic              lru_enable;
  logic              lru_hit;
  logic [1:0]        lru_index;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              fill_we;
  logic [1:0]        fill_way;
  logic [CNT_W-1:0]  fill_word;
  logic [31:0]       fill_data;

  modport master (
    input  req_valid, req_addr, req_hit, req_hit_way, lru_way, victim_dirty,
           victim_tag, victim_rdata, mem_ack, mem_rdata,
    output busy, done, lru_enable, lru_hit, lru_index, mem_req, mem_we,
           mem_addr, mem_wdata, fill_we, fill_way, fill_word, fill_data
  );

  modport slave (
    output req_valid, req_addr, req_hit, req_hit_way, lru_way, victim_dirty,
           victim_tag, victim_rdata, mem_ack, mem_rdata,
    input  busy, done, lru_enable, lru_hit, lru_index, mem_req, mem_we,
           mem_addr, mem_wdata, fill_we, fill_way, fill_word, fill_data
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Miss/refill controller for a 4-way set-associative data cache.
// Hits produce a one-cycle LRU recency update; misses write back the dirty
// LRU victim line, refill that way from memory, then mark it MRU.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : cache_fill_ctrl_if.master (request, lru, victim, memory, fill)
//
// state  | meaning
// IDLE   | accepting requests; hits complete here with a registered pulse
// WB     | writing the dirty victim line to memory, one word per ack
// FILL   | reading the requested line from memory into the victim way
// UPDATE | one cycle: mark the refilled way MRU, signal done
module cache_fill_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4,
  parameter int WORDS   = 4
) (
  input logic clk,
  input logic reset,
  cache_fill_ctrl_if.master bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W - 2;
  localparam int LOW_W = INDEX_W + OFF_W + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(WORDS * 4 - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, UPDATE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        victim_q;
  logic [TAG_W-1:0]  tag_q;
  logic              hit_q;
  logic [1:0]        hit_way_q;
  logic              fill_we_q;
  logic [CNT_W-1:0]  fill_word_q;
  logic [31:0]       fill_data_q;

  logic              accept_hit, accept_miss, ack, cnt_last;
  logic [ADDR_W-1:0] word_off, wb_addr, fill_addr;

  assign accept_hit  = (state == IDLE) && bus.req_valid && bus.req_hit;
  assign accept_miss = (state == IDLE) && bus.req_valid && !bus.req_hit;
  // Acks are only meaningful while a transfer is requested.
  assign ack         = bus.mem_ack && ((state == WB) || (state == FILL));
  assign cnt_last    = (cnt == CNT_W'(WORDS - 1));

  // Line addresses are built by masking the word-offset field and inserting
  // cnt, which also covers WORDS = 1 where that field is empty.
  assign word_off  = ADDR_W'(cnt) << 2;
  assign wb_addr   = ({tag_q, addr_q[LOW_W-1:0]} & ~LINE_MASK) | word_off;
  assign fill_addr = (addr_q & ~LINE_MASK) | word_off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_miss) state_nxt = bus.victim_dirty ? WB : FILL;
      WB:      if (ack && cnt_last) state_nxt = FILL;
      FILL:    if (ack && cnt_last) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      addr_q      <= '0;
      victim_q    <= '0;
      tag_q       <= '0;
      hit_q       <= 1'b0;
      hit_way_q   <= '0;
      fill_we_q   <= 1'b0;
      fill_word_q <= '0;
      fill_data_q <= '0;
    end else begin
      hit_q     <= accept_hit;
      hit_way_q <= accept_hit ? bus.req_hit_way : 2'd0;
      fill_we_q <= ack && (state == FILL);
      if (ack && (state == FILL)) begin
        fill_word_q <= cnt;
        fill_data_q <= bus.mem_rdata;
      end
      if (accept_miss) begin
        addr_q   <= bus.req_addr;
        victim_q <= bus.lru_way;
        tag_q    <= bus.victim_tag;
      end
      // Wraps to 0 on the last word, so every state exit leaves cnt at 0.
      if (ack) cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
    end
  end

  always_comb begin
    bus.busy       = (state != IDLE);
    bus.done       = 1'b0;
    bus.lru_enable = 1'b0;
    bus.lru_hit    = 1'b0;
    bus.lru_index  = 2'd0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.fill_we    = 1'b0;
    bus.fill_way   = 2'd0;
    bus.fill_word  = '0;
    bus.fill_data  = '0;
    case (state)
      IDLE: begin
        bus.done       = hit_q;
        bus.lru_enable = hit_q;
        bus.lru_hit    = hit_q;
        bus.lru_index  = hit_way_q;
      end
      WB: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = wb_addr;
        bus.mem_wdata = bus.victim_rdata;
        // fill_way/fill_word select the victim word being written back.
        bus.fill_way  = victim_q;
        bus.fill_word = cnt;
      end
      FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = fill_addr;
        bus.fill_way = victim_q;
      end
      UPDATE: begin
        bus.done       = 1'b1;
        bus.lru_enable = 1'b1;
        bus.lru_hit    = 1'b1;
        bus.lru_index  = victim_q;
        bus.fill_way   = victim_q;
      end
      default: ;
    endcase
    // Refill write lags its ack by one cycle; the last one lands in UPDATE.
    if (fill_we_q) begin
      bus.fill_we   = 1'b1;
      bus.fill_way  = victim_q;
      bus.fill_word = fill_word_q;
      bus.fill_data = fill_data_q;
    end
  end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
module tb_cache_fill_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  cache_fill_ctrl_if bus ();

  cache_fill_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Victim line word k reads as BEEF000k; memory returns CAFE00xx with the
  // low address byte, so refill data is predictable from the address.
  assign bus.victim_rdata = 32'hBEEF_0000 | 32'(bus.fill_word);
  assign bus.mem_rdata    = 32'hCAFE_0000 | {24'h0, bus.mem_addr[7:0]};

  // Per-run observation logs filled by run_miss.
  logic [31:0] xf_addr[0:15];
  logic        xf_we[0:15];
  logic [31:0] xf_wdata[0:15];
  int          xf_cyc[0:15];
  int          n_xf;
  logic [1:0]  fl_way[0:15];
  logic [1:0]  fl_word[0:15];
  logic [31:0] fl_data[0:15];
  int          fl_cyc[0:15];
  int          n_fl;
  logic [31:0] cyc_addr[0:47];
  int          done_cnt, done_cyc;
  logic [1:0]  done_idx;

  // Presents a miss in cycle 1 and holds it until done; only records.
  task automatic run_miss(input logic [31:0] addr, input logic [1:0] way,
                          input logic dirty, input logic [23:0] tag,
                          input int ack_period, input bit spurious);
    n_xf = 0; n_fl = 0; done_cnt = 0; done_cyc = 0; done_idx = 2'd0;
    for (int i = 0; i < 48; i++) cyc_addr[i] = 32'h0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_hit = 1'b0; bus.req_addr = addr;
    bus.lru_way = way; bus.victim_dirty = dirty; bus.victim_tag = tag;
    for (int c = 1; c < 48; c++) begin
      bus.mem_ack = ((c % ack_period) == 0);
      if (spurious && c == 4) begin
        bus.req_hit = 1'b1; bus.req_hit_way = 2'd0; bus.req_addr = 32'hFFFF_FFF0;
      end
      if (spurious && c == 6) begin
        bus.req_hit = 1'b0; bus.req_addr = addr;
      end
      @(negedge clk);
      if (bus.mem_req) cyc_addr[c] = bus.mem_addr;
      if (bus.mem_req && bus.mem_ack && n_xf < 16) begin
        xf_addr[n_xf] = bus.mem_addr; xf_we[n_xf] = bus.mem_we;
        xf_wdata[n_xf] = bus.mem_wdata; xf_cyc[n_xf] = c; n_xf++;
      end
      if (bus.fill_we && n_fl < 16) begin
        fl_way[n_fl] = bus.fill_way; fl_word[n_fl] = bus.fill_word;
        fl_data[n_fl] = bus.fill_data; fl_cyc[n_fl] = c; n_fl++;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) begin done_cyc = c; done_idx = bus.lru_index; end
        bus.req_valid = 1'b0; bus.req_hit = 1'b0;
      end
      if (done_cyc != 0 && c >= done_cyc + 2) break;
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [150:0] outs;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_held mem_req=%b done=%b required 0 0", bus.mem_req, bus.done);
    end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    outs = {bus.busy, bus.done, bus.lru_enable, bus.lru_hit, bus.lru_index, bus.mem_req,
            bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.fill_we, bus.fill_way,
            bus.fill_word, bus.fill_data};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got %h required all zero", outs);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b required 0", bus.busy);
    end
  endtask

  task automatic test_hit();
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_hit = 1'b1; bus.req_hit_way = 2'd2;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_hit = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.lru_enable, bus.lru_hit, bus.lru_index, bus.done, bus.busy} !== 6'b11_10_1_0) begin
      errors++;
      $display("FAIL hit_update en=%b hit=%b idx=%0d done=%b busy=%b required 1 1 2 1 0",
               bus.lru_enable, bus.lru_hit, bus.lru_index, bus.done, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.lru_enable !== 1'b0) begin
      errors++; $display("FAIL hit_pulse_width done=%b en=%b required 0 0", bus.done, bus.lru_enable);
    end
  endtask

  task automatic test_clean_miss();
    run_miss(32'h0000_1230, 2'd1, 1'b0, 24'h0, 1, 1'b0);
    checks++;
    if (n_xf !== 4 || n_fl !== 4) begin
      errors++; $display("FAIL clean_counts xfers=%0d fills=%0d required 4 4", n_xf, n_fl);
    end
    for (int k = 0; k < 4 && k < n_xf; k++) begin
      checks++;
      if (xf_addr[k] !== 32'h1230 + 32'(4 * k) || xf_we[k] !== 1'b0 || xf_cyc[k] !== k + 2) begin
        errors++;
        $display("FAIL clean_read%0d addr=%h we=%b cyc=%0d required %h 0 %0d",
                 k, xf_addr[k], xf_we[k], xf_cyc[k], 32'h1230 + 32'(4 * k), k + 2);
      end
    end
    for (int k = 0; k < 4 && k < n_fl; k++) begin
      checks++;
      if (fl_way[k] !== 2'd1 || fl_word[k] !== 2'(k) || fl_data[k] !== 32'hCAFE_0030 + 32'(4 * k)
          || fl_cyc[k] !== k + 3) begin
        errors++;
        $display("FAIL clean_fill%0d way=%0d word=%0d data=%h cyc=%0d required 1 %0d %h %0d",
                 k, fl_way[k], fl_word[k], fl_data[k], fl_cyc[k], k,
                 32'hCAFE_0030 + 32'(4 * k), k + 3);
      end
    end
    checks++;
    if (done_cyc !== 6 || done_idx !== 2'd1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL clean_done cyc=%0d idx=%0d count=%0d required 6 1 1", done_cyc, done_idx, done_cnt);
    end
  endtask

  task automatic test_dirty_miss();
    // Tag 0x50 above index 3 gives writeback line 0x00005030.
    run_miss(32'h0000_AB3C, 2'd2, 1'b1, 24'h50, 1, 1'b0);
    checks++;
    if (n_xf !== 8 || n_fl !== 4) begin
      errors++; $display("FAIL dirty_counts xfers=%0d fills=%0d required 8 4", n_xf, n_fl);
    end
    for (int k = 0; k < 4 && k < n_xf; k++) begin
      checks++;
      if (xf_addr[k] !== 32'h5030 + 32'(4 * k) || xf_we[k] !== 1'b1 ||
          xf_wdata[k] !== 32'hBEEF_0000 + 32'(k) || xf_cyc[k] !== k + 2) begin
        errors++;
        $display("FAIL dirty_write%0d addr=%h we=%b wdata=%h cyc=%0d required %h 1 %h %0d",
                 k, xf_addr[k], xf_we[k], xf_wdata[k], xf_cyc[k], 32'h5030 + 32'(4 * k),
                 32'hBEEF_0000 + 32'(k), k + 2);
      end
    end
    for (int k = 4; k < 8 && k < n_xf; k++) begin
      checks++;
      if (xf_addr[k] !== 32'hAB30 + 32'(4 * (k - 4)) || xf_we[k] !== 1'b0 || xf_cyc[k] !== k + 2) begin
        errors++;
        $display("FAIL dirty_read%0d addr=%h we=%b cyc=%0d required %h 0 %0d",
                 k - 4, xf_addr[k], xf_we[k], xf_cyc[k], 32'hAB30 + 32'(4 * (k - 4)), k + 2);
      end
    end
    checks++;
    if (n_fl > 3 && (fl_way[3] !== 2'd2 || fl_word[3] !== 2'd3 || fl_data[3] !== 32'hCAFE_003C ||
        fl_cyc[3] !== 10)) begin
      errors++;
      $display("FAIL dirty_last_fill way=%0d word=%0d data=%h cyc=%0d required 2 3 cafe003c 10",
               fl_way[3], fl_word[3], fl_data[3], fl_cyc[3]);
    end
    checks++;
    if (done_cyc !== 10 || done_idx !== 2'd2 || done_cnt !== 1) begin
      errors++;
      $display("FAIL dirty_done cyc=%0d idx=%0d count=%0d required 10 2 1", done_cyc, done_idx, done_cnt);
    end
  endtask

  task automatic test_slow_ack();
    run_miss(32'h0000_4560, 2'd3, 1'b0, 24'h0, 3, 1'b1);
    checks++;
    if (n_xf !== 4 || n_fl !== 4) begin
      errors++; $display("FAIL slow_counts xfers=%0d fills=%0d required 4 4", n_xf, n_fl);
    end
    for (int k = 0; k < 4 && k < n_xf; k++) begin
      checks++;
      if (xf_addr[k] !== 32'h4560 + 32'(4 * k) || xf_cyc[k] !== 3 * (k + 1)) begin
        errors++;
        $display("FAIL slow_read%0d addr=%h cyc=%0d required %h %0d",
                 k, xf_addr[k], xf_cyc[k], 32'h4560 + 32'(4 * k), 3 * (k + 1));
      end
    end
    checks++;
    if (cyc_addr[2] !== 32'h4560 || cyc_addr[5] !== 32'h4564 || cyc_addr[11] !== 32'h456C) begin
      errors++;
      $display("FAIL slow_hold c2=%h c5=%h c11=%h required 4560 4564 456c",
               cyc_addr[2], cyc_addr[5], cyc_addr[11]);
    end
    checks++;
    if (n_fl > 3 && (fl_way[3] !== 2'd3 || fl_cyc[3] !== 13)) begin
      errors++; $display("FAIL slow_last_fill way=%0d cyc=%0d required 3 13", fl_way[3], fl_cyc[3]);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 13 || done_idx !== 2'd3) begin
      errors++;
      $display("FAIL slow_done count=%0d cyc=%0d idx=%0d required 1 13 3", done_cnt, done_cyc, done_idx);
    end
  endtask

  task automatic test_reset_mid_fill();
    int n_done = 0;
    int n_req = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_hit = 1'b0; bus.req_addr = 32'h0000_2220;
    bus.lru_way = 2'd1; bus.victim_dirty = 1'b0; bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL rst_pre busy=%b mem_req=%b required 1 1", bus.busy, bus.mem_req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_async mem_req=%b busy=%b required 0 0", bus.mem_req, bus.busy);
    end
    bus.req_valid = 1'b0; bus.mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done) n_done++;
      if (bus.mem_req || bus.fill_we) n_req++;
    end
    bus.mem_ack = 1'b0;
    checks++;
    if (n_done !== 0 || n_req !== 0) begin
      errors++; $display("FAIL rst_abandon done=%0d req_or_fill=%0d required 0 0", n_done, n_req);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) begin
        bus.req_valid = 1'b1; bus.req_hit = 1'b1; bus.req_hit_way = 2'(c - 1);
      end else begin
        bus.req_valid = 1'b0; bus.req_hit = 1'b0;
      end
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        checks++;
        if (bus.done !== 1'b1 || bus.lru_enable !== 1'b1 || bus.lru_index !== 2'(c - 2)) begin
          errors++;
          $display("FAIL b2b_hit%0d done=%b en=%b idx=%0d required 1 1 %0d",
                   c - 2, bus.done, bus.lru_enable, bus.lru_index, c - 2);
        end
      end else begin
        checks++;
        if (bus.done !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_c%0d done=%b required 0", c, bus.done);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_hit = 1'b0; bus.req_hit_way = 2'd0;
    bus.lru_way = 2'd0; bus.victim_dirty = 1'b0; bus.victim_tag = '0; bus.mem_ack = 1'b0;
    test_reset();
    test_hit();
    test_clean_miss();
    test_dirty_miss();
    test_slow_ack();
    test_reset_mid_fill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
